// File: rtl/sar_adc_seq_ctrl.sv
// Sequencer for a 12-bit asynchronous-set SAR ADC: arm, bit-trial strobes 11..1, capture.
// Optional back-to-back conversions via the CONT input when SAR_CONT_EN is defined.
module sar_adc_seq_ctrl #(
  parameter int unsigned RST_CYC = 2,
  parameter int unsigned PULSE_W = 1,
  parameter int unsigned GAP_W   = 2
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_start,
  input  logic        i_abort,
`ifdef SAR_CONT_EN
  input  logic        i_cont,
`endif
  input  logic [11:0] i_wp,
  input  logic        i_sar_reg0,
  output logic        o_wp_rstn,
  output logic [11:1] o_pulse,
  output logic        o_busy,
  output logic        o_done,
  output logic [11:0] o_dout
);

  if ((RST_CYC == 0) || (RST_CYC > 15)) begin : g_bad_rst_cyc
    $error("RST_CYC must be in 1..15");
  end
  if ((PULSE_W == 0) || (PULSE_W > 15)) begin : g_bad_pulse_w
    $error("PULSE_W must be in 1..15");
  end
  if ((GAP_W == 0) || (GAP_W > 15)) begin : g_bad_gap_w
    $error("GAP_W must be in 1..15");
  end

  localparam logic [3:0] RstLast   = 4'(RST_CYC - 1);
  localparam logic [3:0] PulseLast = 4'(PULSE_W - 1);
  localparam logic [3:0] GapLast   = 4'(GAP_W - 1);

  typedef enum logic [2:0] {StIdle, StArm, StPhi, StPlo, StCapt} state_e;

  state_e      r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic [3:0]  r_k, w_k_nxt;
  logic        r_relaunch, w_relaunch_nxt;
  logic        r_kill, w_kill_nxt;
  logic        r_capt;
  logic        r_done;
  logic        r_busy;
  logic        r_wp_rstn, w_wp_rstn_nxt;
  logic [11:1] r_pulse, w_pulse_nxt;
  logic [11:0] r_dout;
  logic        w_cont;
  logic        w_unused_wp0;

`ifdef SAR_CONT_EN
  assign w_cont = i_cont;
`else
  assign w_cont = 1'b0;
`endif

  // WP[0] is not part of the result; the LSB comes from SAR_REG0.
  assign w_unused_wp0 = i_wp[0];

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_k_nxt        = r_k;
    w_relaunch_nxt = 1'b0;
    w_kill_nxt     = 1'b0;
    case (r_state)
      StIdle: begin
        if (i_start || r_relaunch) begin
          w_state_nxt = StArm;
          w_cnt_nxt   = 4'd0;
        end
      end
      StArm: begin
        if (i_abort) begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = 4'd0;
          w_kill_nxt  = 1'b1;
        end else if (r_cnt == RstLast) begin
          w_state_nxt = StPhi;
          w_cnt_nxt   = 4'd0;
          w_k_nxt     = 4'd11;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      StPhi: begin
        if (i_abort) begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = 4'd0;
          w_kill_nxt  = 1'b1;
        end else if (r_cnt == PulseLast) begin
          w_state_nxt = StPlo;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      StPlo: begin
        if (i_abort) begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = 4'd0;
          w_kill_nxt  = 1'b1;
        end else if (r_cnt == GapLast) begin
          w_cnt_nxt = 4'd0;
          if (r_k > 4'd1) begin
            w_k_nxt     = r_k - 4'd1;
            w_state_nxt = StPhi;
          end else begin
            w_state_nxt = StCapt;
          end
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      StCapt: begin
        // A continued conversion passes through one IDLE cycle with BUSY held high.
        w_state_nxt    = StIdle;
        w_cnt_nxt      = 4'd0;
        w_relaunch_nxt = w_cont & ~i_abort;
      end
      default: begin
        w_state_nxt = StIdle;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_comb begin
    for (int i = 1; i <= 11; i++) begin
      w_pulse_nxt[i] = (r_state == StPhi) && (r_k == 4'(i));
    end
  end

  always_comb begin
    w_wp_rstn_nxt = r_wp_rstn;
    if (r_kill) begin
      w_wp_rstn_nxt = 1'b0;
    end else begin
      case (r_state)
        StArm:                w_wp_rstn_nxt = 1'b0;
        StPhi, StPlo, StCapt: w_wp_rstn_nxt = 1'b1;
        default:              w_wp_rstn_nxt = r_wp_rstn;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state    <= StIdle;
      r_cnt      <= 4'd0;
      r_k        <= 4'd0;
      r_relaunch <= 1'b0;
      r_kill     <= 1'b0;
      r_capt     <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_wp_rstn  <= 1'b0;
      r_pulse    <= '0;
      r_dout     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_k        <= w_k_nxt;
      r_relaunch <= w_relaunch_nxt;
      r_kill     <= w_kill_nxt;
      r_capt     <= (r_state == StCapt);
      r_done     <= r_capt;
      r_busy     <= (r_state != StIdle) | r_relaunch;
      r_wp_rstn  <= w_wp_rstn_nxt;
      r_pulse    <= w_pulse_nxt;
      if (r_state == StCapt) begin
        r_dout <= {i_wp[11:1], i_sar_reg0};
      end
    end
  end

  assign o_wp_rstn = r_wp_rstn;
  assign o_pulse   = r_pulse;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_dout    = r_dout;

endmodule

// File: tb/tb_sar_adc_seq_ctrl.sv
// Randomised scoreboard bench for sar_adc_seq_ctrl with a timeline reference model.
// Define SAR_CONT_EN to also exercise back-to-back conversions.
module tb_sar_adc_seq_ctrl;
`ifdef SAR_CONT_EN
  localparam int R = 1;
  localparam int P = 1;
  localparam int G = 1;
`else
  localparam int R = 2;
  localparam int P = 1;
  localparam int G = 2;
`endif
  localparam int L = R + 11 * (P + G) + 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] wp = '0;
  logic        sar_reg0 = 1'b0;
  logic        wp_rstn;
  logic [11:1] pulse;
  logic        busy;
  logic        done;
  logic [11:0] dout;
`ifdef SAR_CONT_EN
  logic        cont = 1'b0;
`endif

  sar_adc_seq_ctrl #(
    .RST_CYC(R),
    .PULSE_W(P),
    .GAP_W  (G)
  ) u_dut (
    .i_clk     (clk),
    .i_rstn    (rstn),
    .i_start   (start),
    .i_abort   (abort),
`ifdef SAR_CONT_EN
    .i_cont    (cont),
`endif
    .i_wp      (wp),
    .i_sar_reg0(sar_reg0),
    .o_wp_rstn (wp_rstn),
    .o_pulse   (pulse),
    .o_busy    (busy),
    .o_done    (done),
    .o_dout    (dout)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    logic [11:0] d;
    int          e;
  } exp_t;
  exp_t sb[$];

  // Reference timeline: s = sample edge of the accepted START, kill = first edge after an abort.
  int          s = -1;
  int          kill = -1;
  logic        wp_prev = 1'b0;
  logic [11:0] dout_prev = '0;
  logic [11:0] tgt = '0;
  bit          model_on = 1'b0;
  int          bmode = 0;
  bit          final_chk = 1'b0;
  bit          final_done = 1'b0;
  int          checks = 0;
  int          errors = 0;

  function automatic void model(input int e, output logic x_busy, output logic x_done,
                                output logic x_wp, output logic [11:1] x_pulse,
                                output logic [11:0] x_dout);
    int t, j, ph;
    x_busy  = 1'b0;
    x_done  = 1'b0;
    x_pulse = '0;
    x_wp    = wp_prev;
    x_dout  = dout_prev;
    if (s >= 0) begin
      t = e - s;
      if (kill >= 0 && e >= kill) begin
        x_wp = 1'b0;
      end else if (t >= 1) begin
        x_busy = (t <= L - 1);
        x_wp   = (t > R);
        x_done = (t == L);
        if (t >= L - 1) x_dout = tgt;
        if (t > R && t <= R + 11 * (P + G)) begin
          j  = (t - R - 1) / (P + G);
          ph = (t - R - 1) % (P + G);
          if (ph < P) x_pulse[11-j] = 1'b1;
        end
      end
    end
  endfunction

  function automatic bit accepted(input int smp);
    if (s < 0) return 1'b1;
    if (kill >= 0) return smp >= kill;
    return (smp - s) >= L;
  endfunction

  // SAR logic stand-in: each strobe resolves its bit to the target code.
  always @(negedge clk) begin
    if (wp_rstn !== 1'b1) begin
      wp       <= '0;
      sar_reg0 <= 1'b0;
    end else begin
      for (int k = 1; k <= 11; k++) if (pulse[k] === 1'b1) wp[k] <= tgt[k];
      if (pulse[1] === 1'b1) sar_reg0 <= tgt[0];
    end
  end

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge %0d: got 0x%0h, want 0x%0h", nm, edge_n, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    logic        xb, xd, xw;
    logic [11:1] xp;
    logic [11:0] xdo;
    exp_t        ex;
    if (model_on) begin
      model(edge_n, xb, xd, xw, xp, xdo);
      chk("busy", int'(busy), int'(xb));
      chk("done", int'(done), int'(xd));
      chk("wp_rstn", int'(wp_rstn), int'(xw));
      chk("pulse", int'(pulse), int'(xp));
      chk("dout", int'(dout), int'(xdo));
    end
    if (bmode != 0) chk("cont_busy", int'(busy), (bmode == 1) ? 1 : 0);
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected edge %0d: got DONE with dout 0x%0h, want none",
                 edge_n, dout);
      end else begin
        ex = sb.pop_front();
        chk("sb_dout", int'(dout), int'(ex.d));
        chk("sb_edge", edge_n, ex.e);
      end
    end
    if (sb.size() > 0 && edge_n > sb[0].e) begin
      checks++;
      errors++;
      $display("FAIL done_missing: got no DONE by edge %0d, want one at edge %0d",
               edge_n, sb[0].e);
      void'(sb.pop_front());
    end
    if (final_chk && !final_done) begin
      chk("sb_empty", sb.size(), 0);
      final_done = 1'b1;
    end
  end

  task automatic cyc(input bit st, input bit ab, input bit rs, input logic [11:0] tg);
    int          smp;
    bit          st2;
    logic        xb, xd, xw;
    logic [11:1] xp;
    logic [11:0] xdo;
    @(negedge clk);
    #1;
    smp = edge_n + 1;
    if (rs) begin
      rstn      = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      s         = -1;
      kill      = -1;
      wp_prev   = 1'b0;
      dout_prev = '0;
      sb.delete();
    end else begin
      rstn = 1'b1;
      st2  = st;
      // Avoid a restart on the very edge where the previous DONE is shown.
      if (st && s >= 0 && kill < 0 && (smp - s) == L) st2 = 1'b0;
      start = st2;
      abort = ab;
      if (st2 && accepted(smp)) begin
        model(smp, xb, xd, xw, xp, xdo);
        wp_prev   = xw;
        dout_prev = xdo;
        s         = smp;
        kill      = -1;
        tgt       = tg;
        sb.push_back('{tg, smp + L});
      end else if (ab && s >= 0 && kill < 0 && (smp - s) >= 1 && (smp - s) <= L - 2) begin
        kill = smp + 1;
        if (sb.size() > 0) void'(sb.pop_back());
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, 12'h000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, want finish before 1 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r;
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 12'h000);
    model_on = 1'b1;
    idle(2);

    cyc(1'b1, 1'b0, 1'b0, 12'hA5C);
    idle(L + 3);

    // START again mid-conversion is ignored.
    cyc(1'b1, 1'b0, 1'b0, 12'h5A3);
    idle(9);
    cyc(1'b1, 1'b0, 1'b0, 12'hFFF);
    idle(L);

    // Abort at relative edge 15, then a clean conversion.
    cyc(1'b1, 1'b0, 1'b0, 12'h123);
    idle(14);
    cyc(1'b0, 1'b1, 1'b0, 12'h000);
    idle(5);
    cyc(1'b1, 1'b1, 1'b0, 12'h801);
    idle(L + 2);

    // Reset mid-conversion at relative edge 20.
    cyc(1'b1, 1'b0, 1'b0, 12'h7E1);
    idle(19);
    cyc(1'b0, 1'b0, 1'b1, 12'h000);
    idle(3);

    repeat (40) begin
      cyc(1'b1, 1'b0, 1'b0, 12'($urandom));
      n = $urandom_range(L - 10, L + 8);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 399);
        if (r == 0) cyc(1'b0, 1'b0, 1'b1, 12'h000);
        else if (r < 5) cyc(1'b0, 1'b1, 1'b0, 12'h000);
        else if (r < 40) cyc(1'b1, 1'b0, 1'b0, 12'($urandom));
        else if (r == 40) cyc(1'b1, 1'b1, 1'b0, 12'($urandom));
        else idle(1);
      end
    end
    idle(L + 5);

`ifdef SAR_CONT_EN
    cyc(1'b0, 1'b0, 1'b1, 12'h000);
    idle(2);
    model_on = 1'b0;
    cont     = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 12'h3C9);
    for (int i = 2; i <= 4; i++) sb.push_back('{12'h3C9, s + i * L});
    idle(1);
    bmode = 1;
    idle(3 * L + 3);
    cont = 1'b0;
    idle(L - 4);
    bmode = 2;
    idle(1);
    bmode    = 0;
    model_on = 1'b1;
    idle(L + 5);
`endif

    final_chk = 1'b1;
    idle(2);
    if (!final_done) begin
      checks++;
      errors++;
      $display("FAIL final_check: got no scoreboard drain check, want one");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
